// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// slave: the arbiter's view. master: the requesters plus the memory.
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        stall_fetch;
  // data port
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  // memory side
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_valid, if_rdata, stall_fetch,
           dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_valid, if_rdata, stall_fetch,
           dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported fixed-latency memory between
// instruction fetch (read-only) and the data stage (read/write). One access
// in flight; data has priority, bounded by a streak limit so fetch cannot
// starve.
module mem_port_arbiter #(
  parameter int MEM_LAT     = 1,  // mem_en sampled -> mem_rdata valid, >= 1
  parameter int MAX_DSTREAK = 4   // data grants in a row while fetch waits, >= 1
) (
  input  logic              CLK,
  input  logic              EXT_RESET,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [CW-1:0] LAT_INIT   = CW'(MEM_LAT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t          state, state_nxt;
  owner_t          owner;
  logic            owner_we;
  logic [CW-1:0]   lat_cnt;
  logic [SW-1:0]   streak;
  logic [31:0]     if_rdata_q, dm_rdata_q;
  logic            dm_win, if_win;

  // Winner selection, memory drive and next state. Grants are held off while
  // reset is asserted so every output reads 0 during reset.
  always_comb begin
    state_nxt     = state;
    dm_win        = 1'b0;
    if_win        = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    case (state)
      IDLE: begin
        if (!EXT_RESET) begin
          if (bus.dm_req && !(bus.if_req && streak == STREAK_MAX)) dm_win = 1'b1;
          else if (bus.if_req)                                     if_win = 1'b1;
        end
        if (dm_win || if_win) state_nxt = WAIT;
      end
      WAIT:    if (lat_cnt == CW'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (dm_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
      bus.mem_be    = bus.dm_be;
    end else if (if_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr;
      bus.mem_be    = 4'hF;
    end
    bus.dm_gnt      = dm_win;
    bus.if_gnt      = if_win;
    bus.stall_fetch = bus.if_req && !if_win && !EXT_RESET;
  end

  // The valid pulse is a decode of RESP, so an async reset kills it at once.
  assign bus.if_valid = (state == RESP) && (owner == OWN_IF);
  assign bus.dm_valid = (state == RESP) && (owner == OWN_DM);
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;

  // State register.
  always_ff @(posedge CLK or posedge EXT_RESET) begin
    if (EXT_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  // Owner latch, latency countdown, read capture and data streak tracking.
  always_ff @(posedge CLK or posedge EXT_RESET) begin
    if (EXT_RESET) begin
      owner      <= OWN_NONE;
      owner_we   <= 1'b0;
      lat_cnt    <= '0;
      streak     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (dm_win || if_win) begin
        owner    <= dm_win ? OWN_DM : OWN_IF;
        owner_we <= dm_win && bus.dm_we;
        lat_cnt  <= LAT_INIT;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == CW'(1)) begin
          // write completions leave dm_rdata untouched
          if (owner == OWN_IF)                   if_rdata_q <= bus.mem_rdata;
          else if (owner == OWN_DM && !owner_we) dm_rdata_q <= bus.mem_rdata;
        end
      end
      // streak counts data grants that made a waiting fetch wait
      if (dm_win) begin
        if (!bus.if_req)              streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (if_win) begin
        streak <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset/combinational vector table, directed
// multi-cycle sequences, and randomized traffic against a transaction-level
// model. Instance u_dut uses MEM_LAT=1, u_dut3 uses MEM_LAT=3.
module tb_mem_port_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int MAXS  = 4;

  logic CLK = 1'b0;
  logic EXT_RESET = 1'b1;
  logic mem_init = 1'b0;
  logic [31:0] cyc = '0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter_if a();
  mem_port_arbiter_if b();

  mem_port_arbiter #(.MEM_LAT(LAT_A), .MAX_DSTREAK(MAXS)) u_dut (
    .CLK(CLK), .EXT_RESET(EXT_RESET), .bus(a));
  mem_port_arbiter #(.MEM_LAT(LAT_B), .MAX_DSTREAK(MAXS)) u_dut3 (
    .CLK(CLK), .EXT_RESET(EXT_RESET), .bus(b));

  function automatic logic [31:0] f(input int i);
    return 32'h5A00_0011 + 32'(i) * 32'h0001_0307;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  // Memory for instance a: word array indexed by addr[7:2], read pipe of LAT_A.
  logic [31:0]      mem   [64];
  logic [31:0]      rpipe [LAT_A];
  logic [LAT_A-1:0] rvld;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= f(i);
      rvld <= '0;
    end else begin
      if (a.mem_en && a.mem_we)
        mem[a.mem_addr[7:2]] <= merge(mem[a.mem_addr[7:2]], a.mem_wdata, a.mem_be);
      rvld[0]  <= a.mem_en && !a.mem_we;
      rpipe[0] <= mem[a.mem_addr[7:2]];
      for (int i = 1; i < LAT_A; i++) begin
        rvld[i]  <= rvld[i-1];
        rpipe[i] <= rpipe[i-1];
      end
    end
  end
  assign a.mem_rdata = rvld[LAT_A-1] ? rpipe[LAT_A-1] : {16'hDEAD, cyc[15:0]};
  // instance b sees a word that changes every cycle, exposing the capture cycle
  assign b.mem_rdata = {16'hB000, cyc[15:0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    a.if_req = 0; a.if_addr = 0; a.dm_req = 0; a.dm_we = 0;
    a.dm_addr = 0; a.dm_wdata = 0; a.dm_be = 0;
    b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0;
    b.dm_addr = 0; b.dm_wdata = 0; b.dm_be = 0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic do_reset();
    EXT_RESET = 1; mem_init = 1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1 EXT_RESET = 0; mem_init = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Records grant order (bit=1 for fetch) until n grants or a cycle budget.
  task automatic collect(input int n, output logic [15:0] ord, output int got);
    ord = '0; got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      @(negedge CLK);
      if (a.if_gnt || a.dm_gnt) begin ord[got] = a.if_gnt; got++; end
      step();
    end
  endtask

  typedef struct {
    logic rst; logic ifr; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] be;
    logic e_ig; logic e_dg; logic e_en; logic e_we;
    logic [31:0] e_addr; logic [31:0] e_wd; logic [3:0] e_be; logic e_st;
  } vec_t;

  logic [31:0] ref_mem [64];

  initial begin
    vec_t vt [7];
    logic [15:0] ord;
    int got;
    logic [31:0] samp;

    vt[0] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h300, 32'hCAFEBABE, 4'h5,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h5555, 32'h6666, 4'h9,
              1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0};
    vt[2] = '{1'b0, 1'b0, 32'h777, 1'b1, 1'b0, 32'h2004, 32'h1234, 4'h3,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h2004, 32'h1234, 4'h3, 1'b0};
    vt[3] = '{1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h300, 32'hCAFEBABE, 4'h5,
              1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'hCAFEBABE, 4'h5, 1'b1};
    vt[4] = '{1'b0, 1'b1, 32'h84, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'h88, 1'b0, 1'b1, 32'h44, 32'h99, 4'h1,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0};

    // reset state
    do_reset();
    @(negedge CLK);
    chk("reset ctl", {a.if_gnt, a.if_valid, a.stall_fetch, a.dm_gnt, a.dm_valid,
                      a.mem_en, a.mem_we}, 0);
    chk("reset if_rdata", a.if_rdata, 0);
    chk("reset dm_rdata", a.dm_rdata, 0);
    chk("reset mem_addr", a.mem_addr, 0);
    chk("reset b ctl", {b.if_gnt, b.dm_gnt, b.mem_en, b.dm_valid}, 0);

    // vector table: one IDLE-cycle decision from a fresh reset each
    for (int i = 0; i < 7; i++) begin
      do_reset();
      EXT_RESET = vt[i].rst;
      a.if_req = vt[i].ifr; a.if_addr = vt[i].ia;
      a.dm_req = vt[i].dr; a.dm_we = vt[i].dw; a.dm_addr = vt[i].da;
      a.dm_wdata = vt[i].dd; a.dm_be = vt[i].be;
      @(negedge CLK);
      chk($sformatf("vec%0d gnt", i), {a.if_gnt, a.dm_gnt}, {vt[i].e_ig, vt[i].e_dg});
      chk($sformatf("vec%0d en/we", i), {a.mem_en, a.mem_we}, {vt[i].e_en, vt[i].e_we});
      chk($sformatf("vec%0d addr", i), a.mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d wdata", i), a.mem_wdata, vt[i].e_wd);
      chk($sformatf("vec%0d be", i), a.mem_be, vt[i].e_be);
      chk($sformatf("vec%0d stall", i), a.stall_fetch, vt[i].e_st);
    end

    // lone fetch: grant at T, data at T+2
    do_reset();
    a.if_req = 1; a.if_addr = 32'h100;
    @(negedge CLK);
    chk("t1 if_gnt", a.if_gnt, 1);
    chk("t1 mem_en", a.mem_en, 1);
    chk("t1 mem_addr", a.mem_addr, 32'h100);
    chk("t1 stall", a.stall_fetch, 0);
    step(); a.if_req = 0;
    @(negedge CLK);
    chk("t1 T+1 if_valid", a.if_valid, 0);
    step();
    @(negedge CLK);
    chk("t1 T+2 if_valid", a.if_valid, 1);
    chk("t1 if_rdata", a.if_rdata, f(0));
    step();
    @(negedge CLK);
    chk("t1 T+3 if_valid", a.if_valid, 0);

    // data write beats a simultaneous fetch; fetch follows at T+3
    do_reset();
    a.dm_req = 1; a.dm_we = 1; a.dm_addr = 32'h44; a.dm_wdata = 32'h1234_5678; a.dm_be = 4'h6;
    a.if_req = 1; a.if_addr = 32'h80;
    @(negedge CLK);
    chk("t2 gnt", {a.if_gnt, a.dm_gnt}, 2'b01);
    chk("t2 mem_we", a.mem_we, 1);
    chk("t2 mem_be", a.mem_be, 4'h6);
    chk("t2 stall", a.stall_fetch, 1);
    step(); a.dm_req = 0;
    @(negedge CLK);
    chk("t2 T+1", {a.if_gnt, a.dm_valid}, 0);
    step();
    @(negedge CLK);
    chk("t2 T+2 dm_valid", a.dm_valid, 1);
    chk("t2 T+2 if_gnt", a.if_gnt, 0);
    chk("t2 dm_rdata kept", a.dm_rdata, 0);
    step();
    @(negedge CLK);
    chk("t2 T+3 if_gnt", a.if_gnt, 1);
    step(); a.if_req = 0;
    repeat (3) step();
    chk("t2 written word", mem[32'h44 >> 2], merge(f(32'h44 >> 2), 32'h1234_5678, 4'h6));

    // both held: D,D,D,D,F,D,D,D,D,F
    do_reset();
    a.dm_req = 1; a.dm_addr = 32'h10; a.if_req = 1; a.if_addr = 32'h20;
    collect(10, ord, got);
    chk("t3 grant count", got, 10);
    chk("t3 grant order", ord, 16'h0210);
    idle_inputs();

    // MEM_LAT=3 instance: valid at T+4, data sampled at T+3, no grants in between
    do_reset();
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h2000; b.if_req = 1; b.if_addr = 32'h3000;
    @(negedge CLK);
    chk("t4 gnt", {b.if_gnt, b.dm_gnt}, 2'b01);
    chk("t4 mem_addr", b.mem_addr, 32'h2000);
    samp = '0;
    for (int k = 1; k <= 4; k++) begin
      step(); b.dm_req = 0;
      @(negedge CLK);
      if (k == 3) samp = b.mem_rdata;
      chk($sformatf("t4 T+%0d dm_valid", k), b.dm_valid, k == 4);
      chk($sformatf("t4 T+%0d gnt", k), {b.if_gnt, b.dm_gnt, b.mem_en}, 0);
    end
    chk("t4 dm_rdata", b.dm_rdata, samp);
    step();
    @(negedge CLK);
    chk("t4 T+5 if_gnt", b.if_gnt, 1);
    step(); b.if_req = 0;

    // reset while WAIT: access abandoned, next request granted at once
    do_reset();
    a.dm_req = 1; a.dm_we = 0; a.dm_addr = 32'h0C;
    @(negedge CLK);
    chk("t5 dm_gnt", a.dm_gnt, 1);
    step(); a.dm_req = 0; a.if_req = 1; a.if_addr = 32'h10;
    #2 EXT_RESET = 1;
    #1;
    chk("t5 rst outs", {a.if_gnt, a.dm_gnt, a.mem_en, a.mem_we, a.if_valid,
                        a.dm_valid, a.stall_fetch}, 0);
    chk("t5 rst mem_addr", a.mem_addr, 0);
    chk("t5 rst dm_rdata", a.dm_rdata, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("t5 held", {a.if_gnt, a.dm_gnt, a.if_valid, a.dm_valid, a.mem_en}, 0);
    end
    @(posedge CLK); #1;
    EXT_RESET = 0; a.if_req = 0; a.dm_req = 1; a.dm_addr = 32'h0C;
    @(negedge CLK);
    chk("t5 first idle gnt", a.dm_gnt, 1);
    step(); a.dm_req = 0;
    @(negedge CLK);
    chk("t5 T+1 dm_valid", a.dm_valid, 0);
    step();
    @(negedge CLK);
    chk("t5 T+2 dm_valid", a.dm_valid, 1);
    chk("t5 dm_rdata", a.dm_rdata, f(3));
    step();

    // fetch drops while data is busy; streak clears on the next data grant
    do_reset();
    a.dm_req = 1; a.dm_we = 0; a.dm_addr = 32'h48; a.if_req = 1; a.if_addr = 32'h200;
    @(negedge CLK);
    chk("t6 dm_gnt", a.dm_gnt, 1);
    step(); a.if_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t6 T+%0d if_gnt", k), a.if_gnt, 0);
      chk($sformatf("t6 T+%0d mem_en", k), a.mem_en, k == 3);
      chk($sformatf("t6 T+%0d dm_gnt", k), a.dm_gnt, k == 3);
      step();
    end
    a.if_req = 1;
    collect(5, ord, got);
    chk("t6 grant count", got, 5);
    chk("t6 grant order", ord, 16'h0010);
    idle_inputs();

    // random traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = f(i);
    begin : rnd
      int nf, due, stk;
      logic fp, dp, dw, due_own, due_we, idle, edg, efg;
      logic [31:0] fa, da, dd, due_dat, e_ird, e_drd, e_addr;
      logic [3:0] dbe, e_be;
      nf = 0; due = -1; stk = 0; fp = 0; dp = 0; dw = 0;
      due_own = 0; due_we = 0; due_dat = 0; e_ird = 0; e_drd = 0;
      fa = 0; da = 0; dd = 0; dbe = 0;
      for (int c = 0; c < 400; c++) begin
        if (!fp) begin
          if ($urandom_range(0, 2) == 0) begin fp = 1; fa = $urandom; end
        end else if ($urandom_range(0, 9) == 0) fp = 0;
        if (!dp) begin
          if ($urandom_range(0, 1) == 0) begin
            dp = 1; dw = 1'($urandom_range(0, 1)); da = $urandom; dd = $urandom;
            dbe = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 9) == 0) dp = 0;
        a.if_req = fp;   a.if_addr = fp ? fa : $urandom;
        a.dm_req = dp;   a.dm_we = dp ? dw : 1'($urandom_range(0, 1));
        a.dm_addr = dp ? da : $urandom;
        a.dm_wdata = dp ? dd : $urandom;
        a.dm_be = dp ? dbe : 4'($urandom_range(0, 15));
        @(negedge CLK);
        idle = (c >= nf);
        edg  = idle && dp && !(fp && stk == MAXS);
        efg  = idle && fp && !edg;
        e_addr = edg ? da : (efg ? fa : 32'h0);
        e_be   = edg ? dbe : (efg ? 4'hF : 4'h0);
        if (c == due) begin
          if (!due_own)     e_ird = due_dat;
          else if (!due_we) e_drd = due_dat;
        end
        chk("rnd gnt", {a.if_gnt, a.dm_gnt}, {efg, edg});
        chk("rnd en/we/be", {a.mem_en, a.mem_we, a.mem_be}, {edg || efg, edg && dw, e_be});
        chk("rnd mem_addr", a.mem_addr, e_addr);
        chk("rnd mem_wdata", a.mem_wdata, edg ? dd : 32'h0);
        chk("rnd valid", {a.if_valid, a.dm_valid}, {c == due && !due_own, c == due && due_own});
        chk("rnd if_rdata", a.if_rdata, e_ird);
        chk("rnd dm_rdata", a.dm_rdata, e_drd);
        chk("rnd stall", a.stall_fetch, fp && !efg);
        if (edg) begin
          due = c + LAT_A + 1; nf = c + LAT_A + 2; due_own = 1; due_we = dw;
          if (dw) ref_mem[da[7:2]] = merge(ref_mem[da[7:2]], dd, dbe);
          else    due_dat = ref_mem[da[7:2]];
          stk = fp ? ((stk < MAXS) ? stk + 1 : MAXS) : 0;
          dp = 0;
        end else if (efg) begin
          due = c + LAT_A + 1; nf = c + LAT_A + 2; due_own = 0; due_we = 0;
          due_dat = ref_mem[fa[7:2]];
          stk = 0;
          fp = 0;
        end
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule
